// File: rtl/riscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_if
// Bundles the three buses seen by the memory arbiter:
//   if_*      instruction-fetch request/response (pipeline IF stage)
//   ma_*      data request/response (pipeline MA stage)
//   mem_*     the single shared memory bus
//   bus_error pulses with an ack that was produced by a bus timeout
// Modports:
//   master - the arbiter: it masters the shared memory bus and answers the
//            two pipeline requesters
//   slave  - the environment: pipeline stages plus the memory itself
// ---------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              if_ack;

  logic              ma_req;
  logic              ma_we;
  logic [XLEN-1:0]   ma_addr;
  logic [XLEN-1:0]   ma_wdata;
  logic [XLEN/8-1:0] ma_wstrb;
  logic [XLEN-1:0]   ma_rdata;
  logic              ma_ack;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;

  logic              bus_error;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  ma_req, ma_we, ma_addr, ma_wdata, ma_wstrb,
    output ma_rdata, ma_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack,
    output bus_error
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output ma_req, ma_we, ma_addr, ma_wdata, ma_wstrb,
    input  ma_rdata, ma_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack,
    input  bus_error
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-port memory bus between the fetch (IF) and memory-access
// (MA) stages. One transaction at a time; MA wins ties unless fetch has been
// passed over STARVE times in a row while waiting. A busy transaction that
// sees no mem_ack for TIMEOUT cycles is aborted with bus_error so neither
// stage can stall forever.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - riscv_mem_arbiter_if.master (if_*, ma_*, mem_*, bus_error)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; grant decision taken at the next edge
// IF_BUSY | fetch transaction on the bus, waiting for mem_ack/timeout
// MA_BUSY | data transaction on the bus, waiting for mem_ack/timeout
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_mem_arbiter_if.master  bus
);

  localparam int SW = $clog2(STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = XLEN / 8;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    MA_BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;

  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [TW-1:0]   tmo_cnt_q,   tmo_cnt_d;

  logic            grant_ma;
  logic            grant_if;
  logic            busy;
  logic            abort;
  logic            xfer_done;

  logic            if_ack;
  logic            ma_ack;
  logic [XLEN-1:0] if_rdata;
  logic [XLEN-1:0] ma_rdata;
  logic            bus_error;

  // Grant and completion qualifiers shared by the FSM and the datapath.
  // MA keeps priority until fetch has lost STARVE consecutive decisions.
  always_comb begin
    grant_ma  = bus.ma_req && (!bus.if_req || (starve_cnt_q < STARVE_MAX));
    grant_if  = bus.if_req && !grant_ma;
    busy      = (state_q != IDLE);
    // A real mem_ack in the last allowed cycle beats the timeout.
    abort     = busy && !bus.mem_ack && (tmo_cnt_q == TMO_LAST);
    xfer_done = busy && (bus.mem_ack || abort);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ma) begin
          state_d = MA_BUSY;
        end else if (grant_if) begin
          state_d = IF_BUSY;
        end
      end
      IF_BUSY, MA_BUSY: begin
        if (xfer_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Acks and read data are combinational from mem_ack so a
  // zero-wait memory completes in the first busy cycle. Read data is forced
  // to zero outside a real completion, including an aborted one.
  // ---------------------------------------------------------------------
  always_comb begin
    if_ack    = 1'b0;
    ma_ack    = 1'b0;
    if_rdata  = '0;
    ma_rdata  = '0;
    bus_error = 1'b0;
    case (state_q)
      IF_BUSY: begin
        if_ack    = xfer_done;
        bus_error = abort;
        if (bus.mem_ack) begin
          if_rdata = bus.mem_rdata;
        end
      end
      MA_BUSY: begin
        ma_ack    = xfer_done;
        bus_error = abort;
        if (bus.mem_ack) begin
          ma_rdata = bus.mem_rdata;
        end
      end
      default: begin
        if_ack = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus register, starvation and timeout counters: next values
  // ---------------------------------------------------------------------
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (grant_ma) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ma_we;
          mem_addr_d  = bus.ma_addr;
          mem_wdata_d = bus.ma_wdata;
          mem_wstrb_d = bus.ma_wstrb;
          tmo_cnt_d   = '0;
          // Only MA wins over a waiting fetch count toward starvation.
          if (bus.if_req) begin
            if (starve_cnt_q < STARVE_MAX) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end else if (grant_if) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wstrb_d  = '0;
          tmo_cnt_d    = '0;
          starve_cnt_d = '0;
        end
      end
      IF_BUSY, MA_BUSY: begin
        if (xfer_done) begin
          mem_req_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus register, starvation and timeout counters: flops
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign bus.if_ack    = if_ack;
  assign bus.if_rdata  = if_rdata;
  assign bus.ma_ack    = ma_ack;
  assign bus.ma_rdata  = ma_rdata;
  assign bus.bus_error = bus_error;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_mem_arbiter
// Directed scenarios plus a randomized run checked against a transaction-
// level reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int STARVE  = 4;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

  riscv_mem_arbiter #(
    .XLEN    (XLEN),
    .STARVE  (STARVE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ma_req    = 1'b0;
    bus.ma_we     = 1'b0;
    bus.ma_addr   = '0;
    bus.ma_wdata  = '0;
    bus.ma_wstrb  = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h wstrb=%h, expected all zero",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    n_cmp++;
    if ({bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata, bus.ma_rdata} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_acks: got if_ack=%b ma_ack=%b err=%b, expected 0", bus.if_ack, bus.ma_ack, bus.bus_error);
    end
    step();
    rst = 1'b0;
    // spurious mem_ack in IDLE must be ignored
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata, bus.ma_rdata} !== 67'd0) begin
      n_bad++;
      $display("FAIL idle_spurious_ack: got if_ack=%b ma_ack=%b err=%b if_rdata=%h ma_rdata=%h, expected 0",
               bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata, bus.ma_rdata);
    end
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got mem_req=%b, expected 0", bus.mem_req);
    end
  endtask

  task automatic test_single_fetch();
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_n_req: got %b expected 0", bus.mem_req);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 1'b0, 32'h0000_0100, 4'h0}) begin
      n_bad++;
      $display("FAIL fetch_bus: got req=%b we=%b addr=%h wstrb=%h expected 1 0 00000100 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb);
    end
    n_cmp++;
    if (bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_early_ack: got if_ack=%b expected 0", bus.if_ack);
    end
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack, bus.if_rdata, bus.ma_ack, bus.bus_error} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_ack: got if_ack=%b if_rdata=%h ma_ack=%b err=%b expected 1 00500093 0 0",
               bus.if_ack, bus.if_rdata, bus.ma_ack, bus.bus_error);
    end
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.if_ack, bus.if_rdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL fetch_release: got mem_req=%b if_ack=%b if_rdata=%h expected 0",
               bus.mem_req, bus.if_ack, bus.if_rdata);
    end
  endtask

  task automatic test_store();
    step();
    bus.ma_req   = 1'b1;
    bus.ma_we    = 1'b1;
    bus.ma_addr  = 32'h0000_2000;
    bus.ma_wdata = 32'hDEAD_BEEF;
    bus.ma_wstrb = 4'hF;
    step();
    bus.mem_ack   = bus.mem_req;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
        {1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF}) begin
      n_bad++;
      $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h wstrb=%h expected 1 1 00002000 deadbeef f",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    n_cmp++;
    if ({bus.ma_ack, bus.if_ack, bus.bus_error, bus.ma_rdata} !== {3'b100, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL store_ack: got ma_ack=%b if_ack=%b err=%b ma_rdata=%h expected 1 0 0 12345678",
               bus.ma_ack, bus.if_ack, bus.bus_error, bus.ma_rdata);
    end
    step();
    bus.mem_ack = 1'b0;
    bus.ma_req  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.ma_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL store_release: got mem_req=%b ma_ack=%b expected 0 0", bus.mem_req, bus.ma_ack);
    end
  endtask

  // Both requesters hold their request; MA is a store so a fetch that
  // forgets to clear we/wstrb shows up.
  task automatic test_starvation();
    int ma_cnt;
    int if_grants;
    ma_cnt    = 0;
    if_grants = 0;
    step();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0200;
    bus.ma_req   = 1'b1;
    bus.ma_we    = 1'b1;
    bus.ma_addr  = 32'h0000_3000;
    bus.ma_wdata = 32'h0BAD_F00D;
    bus.ma_wstrb = 4'hF;
    for (int cyc = 0; cyc < 60 && if_grants < 2; cyc++) begin
      step();
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.ma_ack) ma_cnt++;
      if (bus.if_ack) begin
        n_cmp++;
        if (ma_cnt !== STARVE) begin
          n_bad++;
          $display("FAIL starve_count round %0d: got %0d MA grants before IF, expected %0d", if_grants, ma_cnt, STARVE);
        end
        n_cmp++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wstrb} !== {1'b0, 32'h0000_0200, 4'h0}) begin
          n_bad++;
          $display("FAIL starve_if_bus: got we=%b addr=%h wstrb=%h expected 0 00000200 0",
                   bus.mem_we, bus.mem_addr, bus.mem_wstrb);
        end
        if_grants++;
        ma_cnt = 0;
      end
    end
    n_cmp++;
    if (if_grants !== 2) begin
      n_bad++;
      $display("FAIL starve_progress: got %0d IF grants expected 2 within budget", if_grants);
    end
    step();
    bus.if_req  = 1'b0;
    bus.ma_req  = 1'b0;
    bus.ma_we   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_timeout(input bit race);
    int  busy_cyc;
    bit  seen;
    busy_cyc = 0;
    seen     = 1'b0;
    step();
    bus.ma_req  = 1'b1;
    bus.ma_we   = 1'b0;
    bus.ma_addr = race ? 32'h0000_3004 : 32'h0000_3008;
    for (int cyc = 0; cyc < TIMEOUT + 40 && !seen; cyc++) begin
      step();
      if (bus.mem_req) busy_cyc++;
      bus.mem_ack   = race && (busy_cyc == TIMEOUT);
      bus.mem_rdata = race ? 32'hCAFE_F00D : 32'hA5A5_A5A5;
      @(negedge clk);
      if (bus.ma_ack) begin
        seen = 1'b1;
        n_cmp++;
        if (busy_cyc !== TIMEOUT) begin
          n_bad++;
          $display("FAIL tmo_cycle race=%0d: ack on busy cycle %0d expected %0d", race, busy_cyc, TIMEOUT);
        end
        n_cmp++;
        if (race) begin
          if ({bus.bus_error, bus.ma_rdata, bus.if_ack} !== {1'b0, 32'hCAFE_F00D, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_race_ack: got err=%b ma_rdata=%h if_ack=%b expected 0 cafef00d 0",
                     bus.bus_error, bus.ma_rdata, bus.if_ack);
          end
        end else begin
          if ({bus.bus_error, bus.ma_rdata, bus.if_ack} !== {1'b1, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL tmo_abort_ack: got err=%b ma_rdata=%h if_ack=%b expected 1 00000000 0",
                     bus.bus_error, bus.ma_rdata, bus.if_ack);
          end
        end
      end else if (bus.bus_error) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tmo_stray_error: got bus_error=1 without ack on busy cycle %0d, expected 0", busy_cyc);
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL tmo_no_ack race=%0d: got no ma_ack within %0d cycles, expected one", race, TIMEOUT + 40);
    end
    step();
    bus.ma_req  = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.bus_error} !== 2'b00) begin
      n_bad++;
      $display("FAIL tmo_release: got mem_req=%b err=%b expected 0 0", bus.mem_req, bus.bus_error);
    end
    // next transaction completes normally
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0400;
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack, bus.bus_error, bus.if_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL tmo_next_grant: got if_ack=%b err=%b if_rdata=%h expected 1 0 00000013",
               bus.if_ack, bus.bus_error, bus.if_rdata);
    end
    step();
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0500;
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy: got mem_req=%b expected 1", bus.mem_req);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.if_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_ack: got if_ack=%b expected 0", bus.if_ack);
    end
    step();
    rst        = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.if_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_drop: got mem_req=%b if_ack=%b expected 0 0", bus.mem_req, bus.if_ack);
    end
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata} !== 35'd0) begin
      n_bad++;
      $display("FAIL rstmid_late_ack: got if_ack=%b ma_ack=%b err=%b if_rdata=%h expected 0",
               bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata);
    end
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got mem_req=%b expected 0", bus.mem_req);
    end
  endtask

  // Random requesters and a memory with 0..3 cycles of wait. The model
  // tracks transactions, not RTL states: who owns the bus, how long memory
  // stalls, and how many MA wins in a row a waiting fetch has suffered.
  task automatic test_random(input int n_cycles);
    bit          busy, who_ma, expect_grant, snap_if, snap_ma, if_cool, ma_cool, was_idle;
    bit          e_if_ack, e_ma_ack;
    int          lat, starve;
    logic [69:0] exp_f, got_f;
    logic [98:0] exp_o, got_o;
    busy = 0; who_ma = 0; expect_grant = 0; snap_if = 0; snap_ma = 0;
    if_cool = 0; ma_cool = 0; lat = 0; starve = 0;
    idle_inputs();
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      step();
      if (!busy) begin
        n_cmp++;
        if (bus.mem_req !== expect_grant) begin
          n_bad++;
          $display("FAIL rnd_grant_presence cyc %0d: got mem_req=%b expected %b", cyc, bus.mem_req, expect_grant);
        end
        if (expect_grant) begin
          who_ma = snap_ma && (!snap_if || starve < STARVE);
          if (who_ma) starve = snap_if ? ((starve < STARVE) ? starve + 1 : STARVE) : 0;
          else        starve = 0;
          exp_f = who_ma ? {1'b1, bus.ma_we, bus.ma_addr, bus.ma_wdata, bus.ma_wstrb}
                         : {1'b1, 1'b0, bus.if_addr, bus.mem_wdata, 4'h0};
          got_f = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
          n_cmp++;
          if (got_f !== exp_f) begin
            n_bad++;
            $display("FAIL rnd_grant cyc %0d: got bus %h expected %h (ma=%0d)", cyc, got_f, exp_f, who_ma);
          end
          busy = 1;
          lat  = $urandom_range(0, 3);
        end
      end
      bus.mem_rdata = $urandom;
      if (busy) begin
        bus.mem_ack = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        bus.mem_ack = ($urandom_range(0, 7) == 0);
      end
      if (if_cool) begin
        bus.if_req = 1'b0;
        if_cool    = 0;
      end else if (!bus.if_req && $urandom_range(0, 1) == 1) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (ma_cool) begin
        bus.ma_req = 1'b0;
        ma_cool    = 0;
      end else if (!bus.ma_req && $urandom_range(0, 1) == 1) begin
        bus.ma_req   = 1'b1;
        bus.ma_we    = 1'($urandom_range(0, 1));
        bus.ma_addr  = $urandom;
        bus.ma_wdata = $urandom;
        bus.ma_wstrb = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      was_idle = !busy;
      e_if_ack = busy && bus.mem_ack && !who_ma;
      e_ma_ack = busy && bus.mem_ack && who_ma;
      exp_o = {busy, e_if_ack, e_ma_ack, 1'b0,
               e_if_ack ? bus.mem_rdata : 32'h0, e_ma_ack ? bus.mem_rdata : 32'h0, 31'h0};
      got_o = {bus.mem_req, bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata, bus.ma_rdata, 31'h0};
      n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL rnd_resp cyc %0d: got req/if_ack/ma_ack/err=%b%b%b%b if_rd=%h ma_rd=%h expected %b%b%b0 if_rd=%h ma_rd=%h",
                 cyc, bus.mem_req, bus.if_ack, bus.ma_ack, bus.bus_error, bus.if_rdata, bus.ma_rdata,
                 busy, e_if_ack, e_ma_ack, exp_o[97:66], exp_o[65:34]);
      end
      if (e_if_ack) begin if_cool = 1; busy = 0; end
      if (e_ma_ack) begin ma_cool = 1; busy = 0; end
      if (was_idle) begin
        snap_if      = bus.if_req;
        snap_ma      = bus.ma_req;
        expect_grant = snap_if || snap_ma;
      end else begin
        expect_grant = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_starvation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $fatal(1, "watchdog");
  end

endmodule
